riscv_mem_arbiter: RTL and testbench

//  Parametrised N-master to single-memory arbiter for the RISC-V SOPC. Lets instruction

---
 rtl/riscv_mem_arbiter.sv | 111 +++++++++++
 tb/tb_riscv_mem_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: N-master to single-memory arbiter with req/ack handshake and wait states.
// Define RISCV_MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module riscv_mem_arbiter #(
  parameter int NUM_M       = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M-1:0]           m_req_i,
  input  logic [NUM_M-1:0]           m_we_i,
  input  logic [NUM_M*ADDR_W-1:0]    m_addr_i,
  input  logic [NUM_M*DATA_W/8-1:0]  m_sel_i,
  input  logic [NUM_M*DATA_W-1:0]    m_data_i,
  output logic [NUM_M-1:0]           m_ack_o,
  output logic [DATA_W-1:0]          m_data_o,
  output logic                       mem_ce_o,
  output logic                       mem_we_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W/8-1:0]        mem_sel_o,
  output logic [DATA_W-1:0]          mem_data_o,
  input  logic [DATA_W-1:0]          mem_data_i
);
  localparam int SW = DATA_W / 8;
  localparam int IW = $clog2(NUM_M);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, ptr_q, ptr_d, win;
  logic [3:0] cnt_q, cnt_d;
  logic g_req, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [SW-1:0] g_sel;
  logic [DATA_W-1:0] g_data;
  always_comb begin
    g_req = 1'b0;
    g_we = 1'b0;
    g_addr = '0;
    g_sel = '0;
    g_data = '0;
    for (int i = 0; i < NUM_M; i++)
      if (grant_q == IW'(i)) begin
        g_req = m_req_i[i];
        g_we = m_we_i[i];
        g_addr = m_addr_i[i*ADDR_W +: ADDR_W];
        g_sel = m_sel_i[i*SW +: SW];
        g_data = m_data_i[i*DATA_W +: DATA_W];
      end
  end
  // Scan from highest offset down so the closest requester to the search start wins.
  always_comb begin
    win = '0;
    for (int k = NUM_M - 1; k >= 0; k--)
`ifdef RISCV_MEM_ARB_FIXED_PRIO_EN
      if (m_req_i[k]) win = IW'(k);
`else
      if (m_req_i[(int'(ptr_q) + k) % NUM_M]) win = IW'((int'(ptr_q) + k) % NUM_M);
`endif
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    m_ack_o = '0;
    m_data_o = '0;
    mem_ce_o = 1'b0;
    mem_we_o = 1'b0;
    mem_addr_o = '0;
    mem_sel_o = '0;
    mem_data_o = '0;
    if (state_q == IDLE) begin
      if (|m_req_i) begin
        state_d = ACCESS;
        grant_d = win;
        cnt_d = 4'(WAIT_CYCLES);
`ifdef RISCV_MEM_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = (win == IW'(NUM_M - 1)) ? '0 : win + 1'b1;
`endif
      end
    end else if (!g_req) begin
      state_d = IDLE;
    end else begin
      mem_ce_o = 1'b1;
      mem_we_o = g_we;
      mem_addr_o = g_addr;
      mem_sel_o = g_sel;
      mem_data_o = g_data;
      cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      if (cnt_q == 4'd0) begin
        m_ack_o[grant_q] = 1'b1;
        m_data_o = g_we ? '0 : mem_data_i;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed checks of two arbiter instances (2 masters/2 waits, 4 masters/0 waits).
module tb_riscv_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic rst_a, rst_b;
  logic [1:0] a_req, a_we, a_ack;
  logic [63:0] a_addr, a_wd;
  logic [7:0] a_sel;
  logic [31:0] a_rd, a_maddr, a_mwd, a_mrd;
  logic [3:0] a_msel;
  logic a_ce, a_mwe;
  logic [3:0] b_req, b_ack;
  logic [127:0] b_addr, b_wd;
  logic [15:0] b_sel;
  logic [31:0] b_rd, b_maddr, b_mwd, b_mrd;
  logic [3:0] b_msel;
  logic b_ce, b_mwe;
  assign a_mrd = (a_maddr == 32'h100) ? 32'hDEADBEEF : ~a_maddr;
  assign b_mrd = ~b_maddr;
  riscv_mem_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_a), .m_req_i(a_req), .m_we_i(a_we), .m_addr_i(a_addr),
    .m_sel_i(a_sel), .m_data_i(a_wd), .m_ack_o(a_ack), .m_data_o(a_rd),
    .mem_ce_o(a_ce), .mem_we_o(a_mwe), .mem_addr_o(a_maddr), .mem_sel_o(a_msel),
    .mem_data_o(a_mwd), .mem_data_i(a_mrd));
  riscv_mem_arbiter #(.NUM_M(4), .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_b), .m_req_i(b_req), .m_we_i(4'b0000), .m_addr_i(b_addr),
    .m_sel_i(b_sel), .m_data_i(b_wd), .m_ack_o(b_ack), .m_data_o(b_rd),
    .mem_ce_o(b_ce), .mem_we_o(b_mwe), .mem_addr_o(b_maddr), .mem_sel_o(b_msel),
    .mem_data_o(b_mwd), .mem_data_i(b_mrd));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    a_req = 2'b11; a_we = 2'b00;
    a_addr = {32'h100, 32'h40}; a_sel = 8'hFF; a_wd = {32'h22222222, 32'h11111111};
    b_req = 4'b1111; b_sel = 16'hFFFF; b_wd = '0;
    b_addr = {32'h40, 32'h30, 32'h20, 32'h10};
    cyc(); #1;
    chk("a_rst_ce", a_ce, 0); chk("a_rst_ack", a_ack, 0); chk("a_rst_addr", a_maddr, 0);
    chk("a_rst_rd", a_rd, 0); chk("a_rst_we", a_mwe, 0); chk("a_rst_wd", a_mwd, 0);
    chk("b_rst_ce", b_ce, 0); chk("b_rst_ack", b_ack, 0);
    cyc(); #1; chk("a_rst_ce2", a_ce, 0);
    rst_a = 1'b1;
    cyc(); #1; chk("a_c1_ce", a_ce, 1); chk("a_c1_addr", a_maddr, 32'h40); chk("a_c1_ack", a_ack, 0);
    cyc(); #1; chk("a_c2_ce", a_ce, 1); chk("a_c2_ack", a_ack, 0);
    cyc(); #1; chk("a_c3_ack", a_ack, 2'b01); chk("a_c3_rd", a_rd, 32'hFFFFFFBF);
    cyc(); #1; chk("a_c4_ce", a_ce, 0); chk("a_c4_ack", a_ack, 0);
    cyc(); #1; chk("a_c5_ce", a_ce, 1); chk("a_c5_addr", a_maddr, 32'h100);
    cyc(); #1; chk("a_c6_ack", a_ack, 0);
    cyc(); #1; chk("a_c7_ack", a_ack, 2'b10); chk("a_c7_rd", a_rd, 32'hDEADBEEF);
    cyc(); #1; chk("a_c8_ce", a_ce, 0);
    cyc(); #1; chk("a_c9_addr", a_maddr, 32'h40); chk("a_c9_ce", a_ce, 1);
    a_req = 2'b10; #1;
    chk("a_abort_ce", a_ce, 0); chk("a_abort_ack", a_ack, 0);
    cyc(); a_req = 2'b11; #1; chk("a_c10_ce", a_ce, 0);
    cyc(); #1; chk("a_c11_addr", a_maddr, 32'h100);
    cyc(); #1; chk("a_c12_ack", a_ack, 0);
    cyc(); #1; chk("a_c13_ack", a_ack, 2'b10);
    cyc();
    a_req = 2'b10; a_we = 2'b10; a_addr = {32'h20, 32'h40};
    a_sel = 8'h3F; a_wd = {32'h0000ABCD, 32'h11111111};
    #1; chk("a_c14_ce", a_ce, 0);
    cyc(); #1;
    chk("a_wr_ce", a_ce, 1); chk("a_wr_we", a_mwe, 1); chk("a_wr_addr", a_maddr, 32'h20);
    chk("a_wr_sel", a_msel, 4'b0011); chk("a_wr_data", a_mwd, 32'h0000ABCD); chk("a_wr_ack0", a_ack, 0);
    cyc(); #1; chk("a_wr_ack1", a_ack, 0);
    cyc(); #1; chk("a_wr_ack", a_ack, 2'b10); chk("a_wr_rd", a_rd, 0);
    cyc();
    a_req = 2'b01; a_we = 2'b00; a_addr = {32'h100, 32'h40}; a_sel = 8'hFF;
    #1; chk("a_c18_ce", a_ce, 0); chk("a_c18_ack", a_ack, 0);
    cyc(); #1; chk("a_c19_ce", a_ce, 1); chk("a_c19_addr", a_maddr, 32'h40);
    cyc(); rst_a = 1'b0; #1;
    chk("a_midrst_ce", a_ce, 0); chk("a_midrst_ack", a_ack, 0); chk("a_midrst_addr", a_maddr, 0);
    a_req = 2'b11;
    cyc(); #1; chk("a_c21_ce", a_ce, 0); chk("a_c21_ack", a_ack, 0);
    rst_a = 1'b1;
    cyc(); #1; chk("a_restart_addr", a_maddr, 32'h40); chk("a_restart_ce", a_ce, 1);
    cyc(); #1; chk("a_c23_ack", a_ack, 0);
    cyc(); #1; chk("a_c24_ack", a_ack, 2'b01);
    cyc(); a_req = 2'b00;
    b_req = 4'b1010; rst_b = 1'b1;
    cyc(); #1; chk("b_c1_ack", b_ack, 4'b0010); chk("b_c1_ce", b_ce, 1);
    chk("b_c1_addr", b_maddr, 32'h20); chk("b_c1_rd", b_rd, 32'hFFFFFFDF);
    cyc(); #1; chk("b_c2_ack", b_ack, 0); chk("b_c2_ce", b_ce, 0);
    cyc(); #1; chk("b_c3_ack", b_ack, 4'b1000); chk("b_c3_rd", b_rd, 32'hFFFFFFBF);
    cyc(); #1; chk("b_c4_ack", b_ack, 0);
    cyc(); #1; chk("b_c5_ack", b_ack, 4'b0010);
    cyc(); b_req = 4'b1110; #1; chk("b_c6_ack", b_ack, 0);
    cyc(); #1; chk("b_c7_ack", b_ack, 4'b0100); chk("b_c7_addr", b_maddr, 32'h30);
    cyc(); #1; chk("b_c8_ack", b_ack, 0);
    cyc(); #1; chk("b_c9_ack", b_ack, 4'b1000);
    cyc(); #1; chk("b_c10_ack", b_ack, 0);
    cyc(); #1; chk("b_c11_ack", b_ack, 4'b0010);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
